// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue definitions: bubble encoding and the pc+inst entry
// layout reused by IF and ID.
package fetch_queue_pkg;

  localparam logic [31:0] FQ_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  function automatic fq_entry_t fq_make_entry(input logic [31:0] pc,
                                              input logic [31:0] inst);
    fq_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Icache-to-ID handshake bundle for the fetch queue; the slave side is the
// queue itself, the master side is the IF/ID control that drives it.
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              Icache_ready_i;
  logic [INST_W-1:0] Icache_inst_i;
  logic [PC_W-1:0]   Icache_pc_i;
  logic              fc_stall_id_i;
  logic              fc_flush_id_i;
  logic              fc_replay_i;
  logic              fq_valid_o;
  logic [INST_W-1:0] fq_inst_o;
  logic [PC_W-1:0]   fq_pc_o;
  logic              fq_full_o;
  logic [CW-1:0]     fq_count_o;
  logic              fq_overflow_o;

  modport master (
    output Icache_ready_i, Icache_inst_i, Icache_pc_i,
    output fc_stall_id_i, fc_flush_id_i, fc_replay_i,
    input  fq_valid_o, fq_inst_o, fq_pc_o, fq_full_o, fq_count_o, fq_overflow_o
  );

  modport slave (
    input  Icache_ready_i, Icache_inst_i, Icache_pc_i,
    input  fc_stall_id_i, fc_flush_id_i, fc_replay_i,
    output fq_valid_o, fq_inst_o, fq_pc_o, fq_full_o, fq_count_o, fq_overflow_o
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x W register array with one synchronous write port and one
// asynchronous read port; contents are not reset.
module fq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between Icache and ID: DEPTH-entry pc+inst FIFO with an
// optional empty bypass, flush, one-slot load-use replay and backpressure.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = INST_W + PC_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              rp_valid, lc_valid, overflow;
  logic [INST_W-1:0] rp_inst, lc_inst;
  logic [PC_W-1:0]   rp_pc, lc_pc;

  logic [EW-1:0]     ram_rdata;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;

  logic              sel_rp, sel_arr, sel_byp;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              consume, arr_deq, enq_req, enq_ok, replay_take;

  fq_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (enq_ok),
    .waddr (wr_ptr),
    .wdata ({bus.Icache_pc_i, bus.Icache_inst_i}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign head_inst = ram_rdata[INST_W-1:0];
  assign head_pc   = ram_rdata[EW-1:INST_W];

  // Replay slot outranks the array, which outranks the bypassed Icache word.
  always_comb begin
    sel_rp    = rp_valid;
    sel_arr   = !rp_valid && (count != '0);
    sel_byp   = BYPASS && !rp_valid && (count == '0) && bus.Icache_ready_i;
    out_valid = sel_rp || sel_arr || sel_byp;
    out_inst  = INST_W'(FQ_NOP);
    out_pc    = '0;
    if (sel_rp) begin
      out_inst = rp_inst;
      out_pc   = rp_pc;
    end else if (sel_arr) begin
      out_inst = head_inst;
      out_pc   = head_pc;
    end else if (sel_byp) begin
      out_inst = bus.Icache_inst_i;
      out_pc   = bus.Icache_pc_i;
    end

    consume     = out_valid && !bus.fc_stall_id_i && !bus.fc_flush_id_i && !bus.fc_replay_i;
    arr_deq     = consume && sel_arr;
    enq_req     = bus.Icache_ready_i && !bus.fc_flush_id_i && !(consume && sel_byp);
    enq_ok      = enq_req && ((count != FULL_CNT) || arr_deq);
    replay_take = bus.fc_replay_i && lc_valid && !rp_valid && !bus.fc_flush_id_i;
  end

  // Flush shares the reset path so it overrides replay, stall and enqueue.
  always_ff @(posedge clk) begin
    if (rst || bus.fc_flush_id_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rp_valid <= 1'b0;
      lc_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (enq_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (arr_deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq_ok) - CW'(arr_deq);
      if (enq_req && !enq_ok) overflow <= 1'b1;
      if (consume) begin
        lc_valid <= 1'b1;
        lc_inst  <= out_inst;
        lc_pc    <= out_pc;
      end
      if (consume && sel_rp) begin
        rp_valid <= 1'b0;
      end else if (replay_take) begin
        rp_valid <= 1'b1;
        rp_inst  <= lc_inst;
        rp_pc    <= lc_pc;
      end
    end
  end

  assign bus.fq_valid_o    = out_valid;
  assign bus.fq_inst_o     = out_inst;
  assign bus.fq_pc_o       = out_pc;
  assign bus.fq_full_o     = (count == FULL_CNT);
  assign bus.fq_count_o    = count;
  assign bus.fq_overflow_o = overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue: a DEPTH=4 no-bypass instance
// carries the main sequence, a BYPASS=1 instance covers the empty bypass.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fq_entry_t sb[$];
  fq_entry_t exp_ent;
  fq_entry_t last_ent;

  fetch_queue_if #(.DEPTH(4), .INST_W(32), .PC_W(32)) bus0 ();
  fetch_queue_if #(.DEPTH(4), .INST_W(32), .PC_W(32)) bus1 ();

  fetch_queue #(.DEPTH(4), .INST_W(32), .PC_W(32), .BYPASS(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fetch_queue #(.DEPTH(4), .INST_W(32), .PC_W(32), .BYPASS(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle on the no-bypass instance; acc says whether the word must be stored.
  task automatic applyStimulus(input logic rdy, input logic [31:0] inst, input logic [31:0] pc,
                               input logic stall, input logic flush, input logic replay,
                               input logic acc);
    bus0.Icache_ready_i = rdy;
    bus0.Icache_inst_i  = inst;
    bus0.Icache_pc_i    = pc;
    bus0.fc_stall_id_i  = stall;
    bus0.fc_flush_id_i  = flush;
    bus0.fc_replay_i    = replay;
    if (acc) sb.push_back(fq_make_entry(pc, inst));
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus0.fq_valid_o && !bus0.fc_stall_id_i && !bus0.fc_flush_id_i && !bus0.fc_replay_i) begin
      checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_ent = sb.pop_front();
        checkOutput("head_inst", bus0.fq_inst_o, exp_ent.inst);
        checkOutput("head_pc", bus0.fq_pc_o, exp_ent.pc);
        last_ent = exp_ent;
      end
    end
  end

  initial begin
    int budget;
    $display("[TB] fetch_queue bench start");
    rst = 1'b1;
    bus0.Icache_ready_i = 0; bus0.Icache_inst_i = 0; bus0.Icache_pc_i = 0;
    bus0.fc_stall_id_i = 0; bus0.fc_flush_id_i = 0; bus0.fc_replay_i = 0;
    bus1.Icache_ready_i = 0; bus1.Icache_inst_i = 0; bus1.Icache_pc_i = 0;
    bus1.fc_stall_id_i = 0; bus1.fc_flush_id_i = 0; bus1.fc_replay_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_valid", bus0.fq_valid_o, 0);
    checkOutput("rst_inst", bus0.fq_inst_o, 0);
    checkOutput("rst_pc", bus0.fq_pc_o, 0);
    checkOutput("rst_count", bus0.fq_count_o, 0);
    checkOutput("rst_full", bus0.fq_full_o, 0);
    checkOutput("rst_overflow", bus0.fq_overflow_o, 0);
    checkOutput("rst_valid_byp", bus1.fq_valid_o, 0);

    // In-order streaming, each word visible one cycle after entry
    applyStimulus(1, 32'h13, 32'h0, 0, 0, 0, 1);
    checkOutput("s1_count", bus0.fq_count_o, 1);
    checkOutput("s1_pc", bus0.fq_pc_o, 32'h0);
    applyStimulus(1, 32'h93, 32'h4, 0, 0, 0, 1);
    checkOutput("s2_count", bus0.fq_count_o, 1);
    checkOutput("s2_pc", bus0.fq_pc_o, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("s3_count", bus0.fq_count_o, 0);
    checkOutput("s3_valid", bus0.fq_valid_o, 0);

    // Fill under stall
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h100 + 32'(i), 32'h10 + 32'(4 * i), 1, 0, 0, 1);
    checkOutput("fill_count", bus0.fq_count_o, 4);
    checkOutput("fill_full", bus0.fq_full_o, 1);
    checkOutput("fill_overflow", bus0.fq_overflow_o, 0);

    // Full with simultaneous consume and enqueue
    applyStimulus(1, 32'h104, 32'h20, 0, 0, 0, 1);
    checkOutput("full_ce_count", bus0.fq_count_o, 4);
    checkOutput("full_ce_full", bus0.fq_full_o, 1);
    checkOutput("full_ce_overflow", bus0.fq_overflow_o, 0);

    // Two words arrive while full and stalled; both are lost
    applyStimulus(1, 32'h105, 32'h24, 1, 0, 0, 0);
    checkOutput("ovf_flag", bus0.fq_overflow_o, 1);
    applyStimulus(1, 32'h106, 32'h28, 1, 0, 0, 0);
    checkOutput("ovf_count", bus0.fq_count_o, 4);

    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      budget++;
    end
    checkOutput("drain1_left", 32'(sb.size()), 0);
    checkOutput("drain1_count", bus0.fq_count_o, 0);
    checkOutput("drain1_full", bus0.fq_full_o, 0);
    checkOutput("drain1_overflow_sticky", bus0.fq_overflow_o, 1);

    // Load-use replay of pc 0x8 ahead of queued pc 0xC
    applyStimulus(1, 32'h333, 32'h8, 0, 0, 0, 1);
    applyStimulus(1, 32'h444, 32'hC, 0, 0, 0, 1);
    checkOutput("rp_pre_count", bus0.fq_count_o, 1);
    sb.push_front(last_ent);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("rp_valid", bus0.fq_valid_o, 1);
    checkOutput("rp_pc", bus0.fq_pc_o, 32'h8);
    checkOutput("rp_inst", bus0.fq_inst_o, 32'h333);
    checkOutput("rp_count", bus0.fq_count_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rp_next_pc", bus0.fq_pc_o, 32'hC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rp_done_count", bus0.fq_count_o, 0);

    // Flush with 3 queued, replay slot loaded and an Icache word in flight
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'h700 + 32'(i), 32'h40 + 32'(4 * i), 1, 0, 0, 1);
    sb.push_front(last_ent);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("fl_pre_pc", bus0.fq_pc_o, 32'hC);
    checkOutput("fl_pre_count", bus0.fq_count_o, 3);
    applyStimulus(1, 32'h7ff, 32'h4C, 0, 1, 0, 0);
    checkOutput("fl_valid", bus0.fq_valid_o, 0);
    checkOutput("fl_count", bus0.fq_count_o, 0);
    checkOutput("fl_overflow", bus0.fq_overflow_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_idle_valid", bus0.fq_valid_o, 0);

    // Recovery after flush, pointers wrap past DEPTH-1
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 32'h500 + 32'(i), 32'h60 + 32'(4 * i), 0, 0, 0, 1);
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      budget++;
    end
    checkOutput("drain2_left", 32'(sb.size()), 0);
    checkOutput("drain2_count", bus0.fq_count_o, 0);

    // Bypass instance: empty queue presents the Icache word the same cycle
    bus1.Icache_ready_i = 1; bus1.Icache_inst_i = 32'h6f; bus1.Icache_pc_i = 32'h20;
    #1;
    checkOutput("byp_valid", bus1.fq_valid_o, 1);
    checkOutput("byp_pc", bus1.fq_pc_o, 32'h20);
    checkOutput("byp_inst", bus1.fq_inst_o, 32'h6f);
    checkOutput("byp_count", bus1.fq_count_o, 0);
    @(posedge clk);
    #1;
    checkOutput("byp_after_count", bus1.fq_count_o, 0);
    bus1.Icache_inst_i = 32'h6e; bus1.Icache_pc_i = 32'h24; bus1.fc_stall_id_i = 1;
    #1;
    checkOutput("byp_stall_pc", bus1.fq_pc_o, 32'h24);
    @(posedge clk);
    #1;
    bus1.Icache_ready_i = 0; bus1.fc_stall_id_i = 0;
    #1;
    checkOutput("byp_stall_count", bus1.fq_count_o, 1);
    checkOutput("byp_stored_pc", bus1.fq_pc_o, 32'h24);
    @(posedge clk);
    #1;
    checkOutput("byp_final_count", bus1.fq_count_o, 0);
    checkOutput("byp_final_valid", bus1.fq_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
